// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared encodings and default parameters for branch_predictor
package branch_predictor_pkg;

    // Default table geometry and counter behaviour
    localparam int BP_INDEX_BITS = 6;
    localparam int BP_CTR_BITS   = 2;
    localparam int BP_CTR_INIT   = 1;
    localparam int BP_HIST_BITS  = 6;

    // Target-generator select; TGT_GEN_NONE is the unmapped encoding
    typedef enum logic [1:0] {
        TGT_GEN_NONE = 2'b00,
        TGT_GEN_JAL  = 2'b01,
        TGT_GEN_JALR = 2'b10,
        TGT_GEN_BR   = 2'b11
    } tgt_gen_e;

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - one saturating up/down direction counter of the predictor table
module bp_sat_ctr #(
    parameter int CTR_BITS = 2,
    parameter int CTR_INIT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);

    logic [CTR_BITS-1:0] ctr_q;
    logic [CTR_BITS-1:0] ctr_d;

    // Step toward the resolved direction, holding at either end of the range
    always_comb begin
        ctr_d = ctr_q;
        if (en_i) begin
            if (taken_i) begin
                if (ctr_q != CTR_MAX) ctr_d = ctr_q + CTR_BITS'(1);
            end else begin
                if (ctr_q != '0) ctr_d = ctr_q - CTR_BITS'(1);
            end
        end
    end

    // Counter register; reset wins over a coincident update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctr_q <= CTR_RST;
        else       ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch target generator with counter-table direction predictor (optional BP_GSHARE_EN)
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int CTR_BITS   = BP_CTR_BITS,
    parameter int CTR_INIT   = BP_CTR_INIT,
    parameter int HIST_BITS  = BP_HIST_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_en,
    input  logic [1:0]           pred_sel,
    input  logic [31:0]          pred_pc,
    input  logic [31:0]          pred_rd1,
    input  logic [31:0]          pred_imm,
    output logic [31:0]          pred_target,
    output logic                 pred_taken,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [HIST_BITS-1:0] upd_hist,
    output logic [HIST_BITS-1:0] pred_hist
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0]   ctr_vals [DEPTH];
    logic [DEPTH-1:0]      upd_we;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic [CTR_BITS-1:0]   lookup_ctr;
    logic [31:0]           pc_rel_sum;
    logic [31:0]           reg_rel_sum;

`ifdef BP_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_d;

    if (HIST_BITS == 1) begin : g_ghr_one
        assign ghr_d = upd_taken;
    end else begin : g_ghr_many
        assign ghr_d = {ghr_q[HIST_BITS-2:0], upd_taken};
    end

    // Global history shifts in resolved outcomes only (non-speculative)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            ghr_q <= '0;
        else if (upd_valid) ghr_q <= ghr_d;
    end

    assign lookup_idx = pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign update_idx = upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(upd_hist);
    assign pred_hist  = ghr_q;

    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};
`else
    assign lookup_idx = pred_pc[INDEX_BITS+1:2];
    assign update_idx = upd_pc[INDEX_BITS+1:2];
    assign pred_hist  = '0;

    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[31:INDEX_BITS+2], upd_pc[1:0], upd_hist};
`endif

    // One-hot write enable for the counter selected by the resolved branch
    always_comb begin
        upd_we = '0;
        if (upd_valid) upd_we[update_idx] = 1'b1;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_table
        bp_sat_ctr #(
            .CTR_BITS (CTR_BITS),
            .CTR_INIT (CTR_INIT)
        ) u_ctr (
            .clk_i   (clk),
            .rst_i   (rst),
            .en_i    (upd_we[i]),
            .taken_i (upd_taken),
            .ctr_o   (ctr_vals[i])
        );
    end

    // Both adders wrap modulo 2^32
    assign pc_rel_sum  = pred_pc + pred_imm;
    assign reg_rel_sum = pred_rd1 + pred_imm;
    assign lookup_ctr  = ctr_vals[lookup_idx];

    // Zero-latency lookup from registered table state; no bypass of same-cycle updates
    always_comb begin
        pred_target = '0;
        pred_taken  = 1'b0;
        if (pred_en) begin
            case (tgt_gen_e'(pred_sel))
                TGT_GEN_JAL: begin
                    pred_target = pc_rel_sum;
                    pred_taken  = 1'b1;
                end
                TGT_GEN_JALR: begin
                    pred_target = reg_rel_sum & ~32'h1;
                    pred_taken  = 1'b1;
                end
                TGT_GEN_BR: begin
                    if (lookup_ctr[CTR_BITS-1]) begin
                        pred_target = pc_rel_sum;
                        pred_taken  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int HB = BP_HIST_BITS;

    logic          clk;
    logic          rst;
    logic          pred_en;
    logic [1:0]    pred_sel;
    logic [31:0]   pred_pc;
    logic [31:0]   pred_rd1;
    logic [31:0]   pred_imm;
    logic [31:0]   pred_target;
    logic          pred_taken;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [HB-1:0] upd_hist;
    logic [HB-1:0] pred_hist;

    int n_cmp;
    int n_err;

    branch_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .pred_en     (pred_en),
        .pred_sel    (pred_sel),
        .pred_pc     (pred_pc),
        .pred_rd1    (pred_rd1),
        .pred_imm    (pred_imm),
        .pred_target (pred_target),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_hist    (upd_hist),
        .pred_hist   (pred_hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [1:0] sel, input logic [31:0] pc,
                          input logic [31:0] rd1, input logic [31:0] imm);
        pred_en  = 1'b1;
        pred_sel = sel;
        pred_pc  = pc;
        pred_rd1 = rd1;
        pred_imm = imm;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [HB-1:0] hist);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = tk;
        upd_hist  = hist;
        cyc();
        upd_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        pred_en   = 1'b0;
        pred_sel  = TGT_GEN_NONE;
        pred_pc   = '0;
        pred_rd1  = '0;
        pred_imm  = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        upd_hist  = '0;
        #2;
        check("rst_hist", 32'(pred_hist), 32'h0);
        check("rst_taken_idle", 32'(pred_taken), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        // 1: cold BR lookup, counter at 1 -> not taken
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("t1_taken", 32'(pred_taken), 32'h0);
        check("t1_target", pred_target, 32'h0);

        // 2: one taken update -> 2, predicts taken
        train(32'h100, 1'b1, '0);
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("t2_taken", 32'(pred_taken), 32'h1);
        check("t2_target", pred_target, 32'h120);
        for (int i = 0; i < 3; i++) train(32'h100, 1'b1, '0);
        train(32'h100, 1'b0, '0);
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("t2_sat_taken", 32'(pred_taken), 32'h1);
        check("t2_sat_target", pred_target, 32'h120);

        // 3: JALR / JAL targets, disabled and unmapped lookups
        lookup(TGT_GEN_JALR, 32'h0, 32'h1003, 32'h4);
        check("t3_jalr_target", pred_target, 32'h1006);
        check("t3_jalr_taken", 32'(pred_taken), 32'h1);
        lookup(TGT_GEN_JAL, 32'hFFFF_FFF0, 32'h0, 32'h20);
        check("t3_jal_wrap", pred_target, 32'h10);
        check("t3_jal_taken", 32'(pred_taken), 32'h1);
        lookup(TGT_GEN_NONE, 32'h100, 32'h0, 32'h20);
        check("t3_unmapped_taken", 32'(pred_taken), 32'h0);
        check("t3_unmapped_target", pred_target, 32'h0);
        lookup(TGT_GEN_JAL, 32'h100, 32'h0, 32'h20);
        pred_en = 1'b0;
        #1;
        check("t3_disabled_taken", 32'(pred_taken), 32'h0);
        check("t3_disabled_target", pred_target, 32'h0);
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("t3_table_kept", 32'(pred_taken), 32'h1);

        // 4: same-cycle lookup and update on idx 5 (pc 0x14)
        lookup(TGT_GEN_BR, 32'h14, 32'h0, 32'h8);
        upd_valid = 1'b1;
        upd_pc    = 32'h14;
        upd_taken = 1'b1;
        #1;
        check("t4_same_cycle", 32'(pred_taken), 32'h0);
        cyc();
        upd_valid = 1'b0;
        #1;
        check("t4_next_taken", 32'(pred_taken), 32'h1);
        check("t4_next_target", pred_target, 32'h1C);

        // 5: aliasing on idx 0, neighbour idx 1 untouched
        train(32'h100, 1'b1, '0);
        train(32'h100, 1'b1, '0);
        lookup(TGT_GEN_BR, 32'h200, 32'h0, 32'h40);
        check("t5_alias_taken", 32'(pred_taken), 32'h1);
        check("t5_alias_target", pred_target, 32'h240);
        lookup(TGT_GEN_BR, 32'h104, 32'h0, 32'h40);
        check("t5_neighbour", 32'(pred_taken), 32'h0);

        // 6: reset mid-training; the coincident update to idx 1 is dropped
        upd_valid = 1'b1;
        upd_pc    = 32'h104;
        upd_taken = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("t6_in_rst_taken", 32'(pred_taken), 32'h0);
        cyc();
        train(32'h104, 1'b1, '0);
        upd_valid = 1'b0;
        #2;
        rst = 1'b0;
        cyc();
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("t6_idx0", 32'(pred_taken), 32'h0);
        lookup(TGT_GEN_BR, 32'h14, 32'h0, 32'h20);
        check("t6_idx5", 32'(pred_taken), 32'h0);
        lookup(TGT_GEN_BR, 32'h104, 32'h0, 32'h20);
        check("t6_idx1", 32'(pred_taken), 32'h0);
        check("t6_hist", 32'(pred_hist), 32'h0);

`ifdef BP_GSHARE_EN
        // gshare: three taken updates on idx 7 build GHR=000111
        for (int i = 0; i < 3; i++) train(32'h11C, 1'b1, '0);
        check("g_hist", 32'(pred_hist), 32'h07);
        lookup(TGT_GEN_BR, 32'h100, 32'h0, 32'h20);
        check("g_idx7_taken", 32'(pred_taken), 32'h1);
        lookup(TGT_GEN_BR, 32'h11C, 32'h0, 32'h20);
        check("g_idx0_taken", 32'(pred_taken), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
